// File: rtl/shifter_pipe_pkg.sv
// Shared op encodings and helpers for the pipelined barrel shifter.
package shifter_pipe_pkg;

`include "shifter_defs.vh"

  // Codes above ROR are reserved: the result passes through and is flagged.
  function automatic logic isReservedOp(input logic [2:0] op);
    return op > OP_ROR;
  endfunction

endpackage

// File: rtl/shifter_defs.vh
// Operation encodings shared by the shifter pipeline.
`ifndef SHIFTER_DEFS_VH
`define SHIFTER_DEFS_VH

localparam logic [2:0] OP_ROL = 3'b000;
localparam logic [2:0] OP_SLL = 3'b001;
localparam logic [2:0] OP_SRA = 3'b010;
localparam logic [2:0] OP_SRL = 3'b011;
localparam logic [2:0] OP_ROR = 3'b100;

`endif

// File: rtl/shifter_stage.sv
// One mux level of the barrel shifter (shift by 2^K) plus its pipeline register.
module shifter_stage
  import shifter_pipe_pkg::*;
#(
  parameter int N = 16,
  parameter int K = 0,
  localparam int C = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         upValid_i,
  input  logic [N-1:0] upData_i,
  input  logic [C-1:0] upCnt_i,
  input  logic [2:0]   upOp_i,
  input  logic         upSign_i,
  input  logic         upErr_i,
  output logic         dnValid_o,
  input  logic         dnReady_i,
  output logic [N-1:0] dnData_o,
  output logic [C-1:0] dnCnt_o,
  output logic [2:0]   dnOp_o,
  output logic         dnSign_o,
  output logic         dnErr_o
);

  localparam int S = 1 << K;

  logic         valid_q;
  logic [N-1:0] data_q, data_d;
  logic [C-1:0] cnt_q;
  logic [2:0]   op_q;
  logic         sign_q;
  logic         err_q;
  logic         advance;

  // An empty stage always takes new data, even if the stages behind it are stalled.
  assign advance = !valid_q || dnReady_i;

  always_comb begin
    data_d = upData_i;
    if (upCnt_i[K]) begin
      case (upOp_i)
        OP_ROL:  data_d = {upData_i[N-S-1:0], upData_i[N-1:N-S]};
        OP_SLL:  data_d = {upData_i[N-S-1:0], {S{1'b0}}};
        OP_SRA:  data_d = {{S{upSign_i}}, upData_i[N-1:S]};
        OP_SRL:  data_d = {{S{1'b0}}, upData_i[N-1:S]};
        OP_ROR:  data_d = {upData_i[S-1:0], upData_i[N-1:S]};
        default: data_d = upData_i;
      endcase
    end
  end

  // Payload loads only with a valid word so idle-cycle garbage never enters the pipe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
      sign_q  <= 1'b0;
      err_q   <= 1'b0;
    end else if (advance) begin
      valid_q <= upValid_i;
      if (upValid_i) begin
        data_q <= data_d;
        cnt_q  <= upCnt_i;
        op_q   <= upOp_i;
        sign_q <= upSign_i;
        err_q  <= upErr_i;
      end
    end
  end

  assign dnValid_o = valid_q;
  assign dnData_o  = data_q;
  assign dnCnt_o   = cnt_q;
  assign dnOp_o    = op_q;
  assign dnSign_o  = sign_q;
  assign dnErr_o   = err_q;

endmodule

// File: rtl/shifter_pipe.sv
// Pipelined barrel shifter: C single-level stages with a valid/ready handshake.
module shifter_pipe
  import shifter_pipe_pkg::*;
#(
  parameter int N = 16,
  localparam int C = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] In,
  input  logic [C-1:0] Cnt,
  input  logic [2:0]   Op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] Out,
  output logic         op_err
);

  logic [C:0]        validChain;
  logic [C:0]        readyChain;
  logic [C:0]        signChain;
  logic [C:0]        errChain;
  logic [C:0][N-1:0] dataChain;
  logic [C:0][C-1:0] cntChain;
  logic [C:0][2:0]   opChain;
  logic              unusedTail;

  assign validChain[0] = in_valid;
  assign dataChain[0]  = In;
  assign cntChain[0]   = Cnt;
  assign opChain[0]    = Op;
  assign signChain[0]  = In[N-1];
  assign errChain[0]   = isReservedOp(Op);

  // Ready ripples back from the consumer: stage k can take data if it is empty or stage k+1 moves.
  always_comb begin
    readyChain    = '0;
    readyChain[C] = out_ready;
    for (int k = C - 1; k >= 0; k--) begin
      readyChain[k] = !validChain[k+1] || readyChain[k+1];
    end
  end

  for (genvar k = 0; k < C; k++) begin : gStage
    shifter_stage #(.N(N), .K(k)) uStage (
      .clk       (clk),
      .rst_n     (rst_n),
      .upValid_i (validChain[k]),
      .upData_i  (dataChain[k]),
      .upCnt_i   (cntChain[k]),
      .upOp_i    (opChain[k]),
      .upSign_i  (signChain[k]),
      .upErr_i   (errChain[k]),
      .dnValid_o (validChain[k+1]),
      .dnReady_i (readyChain[k+1]),
      .dnData_o  (dataChain[k+1]),
      .dnCnt_o   (cntChain[k+1]),
      .dnOp_o    (opChain[k+1]),
      .dnSign_o  (signChain[k+1]),
      .dnErr_o   (errChain[k+1])
    );
  end

  assign in_ready  = readyChain[0];
  assign out_valid = validChain[C];
  assign Out       = dataChain[C];
  assign op_err    = errChain[C];

  // Shift control is spent after the last level and is intentionally dropped here.
  assign unusedTail = ^{cntChain[C], opChain[C], signChain[C]};

endmodule
